// File: rtl/ssc_pkg.sv
// ssc_pkg: register map, PRN word field helpers and the Galois PRN step
// shared by the spread-spectrum transmitter and the correlator channels.
package ssc_pkg;

    localparam logic [15:0] A_CTRL       = 16'h0800;
    localparam logic [15:0] A_CAR_FREQ   = 16'h0804;
    localparam logic [15:0] A_CAR_PHASE  = 16'h0808;
    localparam logic [15:0] A_CHIP_FREQ  = 16'h080C;
    localparam logic [15:0] A_CHIP_PHASE = 16'h0810;
    localparam logic [15:0] A_PRN        = 16'h0814;
    localparam logic [15:0] A_SAMPLE_DIV = 16'h0818;
    localparam logic [15:0] A_SAMPLE_CNT = 16'h081C;
    localparam logic [15:0] A_AMP        = 16'h0820;
    localparam logic [15:0] A_STATUS     = 16'h0824;

    function automatic logic [3:0] prn_hob(input logic [31:0] w);
        return w[31:28];
    endfunction

    function automatic logic [13:0] prn_poly(input logic [31:0] w);
        return w[27:14];
    endfunction

    function automatic logic [13:0] prn_state(input logic [31:0] w);
        return w[13:0];
    endfunction

    function automatic logic prn_sign(input logic [31:0] w);
        logic [13:0] sh;
        sh = prn_state(w) >> prn_hob(w);
        return sh[0];
    endfunction

    // x = state[hob]; clear it; shift left; fold poly back in when x was set.
    function automatic logic [13:0] prn_step(
        input logic [3:0]  hob,
        input logic [13:0] poly,
        input logic [13:0] state
    );
        logic [13:0] mask;
        logic [13:0] sh;
        logic [13:0] nxt;
        mask = 14'd1 << hob;
        sh   = state >> hob;
        nxt  = (state & ~mask) << 1;
        if (sh[0]) nxt = nxt ^ poly;
        return nxt;
    endfunction

endpackage

// File: rtl/ssc_tx_if.sv
// ssc_tx_if: register bus plus ADC sample stream of the transmitter.
// master = bus driver / sample consumer, slave = the transmitter.
interface ssc_tx_if;
    logic [31:0] addr;
    logic [31:0] Wdata;
    logic        write;
    logic        read;
    logic [31:0] Rdata;
    logic [15:0] ADC;
    logic        pushADC;
    logic        epoch;

    modport master (
        output addr, Wdata, write, read,
        input  Rdata, ADC, pushADC, epoch
    );

    modport slave (
        input  addr, Wdata, write, read,
        output Rdata, ADC, pushADC, epoch
    );
endinterface

// File: rtl/sine.sv
// sine: quarter-wave table, v[12:0] -> positive magnitude sv[15:0].
// Parabolic fit v*(16384-v)/2048: sv(0)=0, sv(1FFF)=32767 (S_MAX).
module sine (
    input  logic [12:0] v,
    output logic [15:0] sv
);
    logic [26:0] prod;

    assign prod = 27'(v) * (27'd16384 - 27'(v));
    assign sv   = prod[26:11];
endmodule

// File: rtl/ssc_tx.sv
// ssc_tx: BPSK-spread carrier source (carrier DDS, chip DDS, Galois PRN,
// sine LUT). Ports: clk, rst (async high), bus = ssc_tx_if.slave.
module ssc_tx
    import ssc_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    ssc_tx_if.slave bus
);
    logic [1:0]  ctrl;
    logic [31:0] car_freq, car_phase;
    logic [31:0] chip_freq, chip_phase;
    logic [31:0] prn;
    logic [31:0] sample_div, sample_count, div_cnt;
    logic [3:0]  amp;
    logic        epoch_seen, epoch_q;

    logic        s1_valid, s1_neg;
    logic [15:0] s1_mag;
    logic [15:0] adc_q;
    logic        push_q;

    logic [15:0] a;
    logic        wr_ctrl, wr_cf, wr_cp, wr_hf, wr_hp;
    logic        wr_prn, wr_div, wr_cnt, wr_amp, rd_status;
    logic        unused_hi;

    assign a         = bus.addr[15:0];
    assign unused_hi = ^bus.addr[31:16];
    assign wr_ctrl   = bus.write && a == A_CTRL;
    assign wr_cf     = bus.write && a == A_CAR_FREQ;
    assign wr_cp     = bus.write && a == A_CAR_PHASE;
    assign wr_hf     = bus.write && a == A_CHIP_FREQ;
    assign wr_hp     = bus.write && a == A_CHIP_PHASE;
    assign wr_prn    = bus.write && a == A_PRN;
    assign wr_div    = bus.write && a == A_SAMPLE_DIV;
    assign wr_cnt    = bus.write && a == A_SAMPLE_CNT;
    assign wr_amp    = bus.write && a == A_AMP;
    assign rd_status = bus.read && a == A_STATUS;

    logic        en, en_next, tick, chip_edge, step_epoch;
    logic [31:0] car_sum, chip_sum;
    logic [13:0] prn_next;
    logic [1:0]  q;
    logic [12:0] lut_v;
    logic [15:0] lut_sv;

    // en_next lets a disabling write kill samples already in the pipe.
    assign en         = ctrl[0];
    assign en_next    = wr_ctrl ? bus.Wdata[0] : en;
    assign tick       = en && (div_cnt == sample_div);
    assign car_sum    = car_phase + car_freq;
    assign chip_sum   = chip_phase + chip_freq;
    assign chip_edge  = tick && !chip_phase[31] && chip_sum[31];
    assign prn_next   = prn_step(prn_hob(prn), prn_poly(prn),
                                 prn_state(prn));
    assign step_epoch = chip_edge && !wr_prn && prn_next == 14'h0001;

    // Odd quadrants run the table backwards.
    assign q     = car_phase[31:30];
    assign lut_v = q[0] ? ~car_phase[29:17] : car_phase[29:17];

    sine u_sine (
        .v  (lut_v),
        .sv (lut_sv)
    );

    logic signed [15:0] s2_val, s2_out;

    always_comb begin
        s2_val = signed'(s1_mag);
        if (s1_neg) begin
            s2_val = (s1_mag == 16'h8000) ? 16'sh7FFF
                                          : -signed'(s1_mag);
        end
        s2_out = s2_val >>> amp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl         <= '0;
            car_freq     <= '0;
            car_phase    <= '0;
            chip_freq    <= '0;
            chip_phase   <= '0;
            prn          <= '0;
            sample_div   <= '0;
            sample_count <= '0;
            div_cnt      <= '0;
            amp          <= '0;
            epoch_seen   <= 1'b0;
            epoch_q      <= 1'b0;
            s1_valid     <= 1'b0;
            s1_neg       <= 1'b0;
            s1_mag       <= '0;
            adc_q        <= '0;
            push_q       <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= bus.Wdata[1:0];
            if (wr_cf)   car_freq <= bus.Wdata;
            if (wr_hf)   chip_freq <= bus.Wdata;
            if (wr_div)  sample_div <= bus.Wdata;
            if (wr_amp)  amp <= bus.Wdata[3:0];

            if (wr_cp)     car_phase <= bus.Wdata;
            else if (tick) car_phase <= car_sum;

            if (wr_hp)     chip_phase <= bus.Wdata;
            else if (tick) chip_phase <= chip_sum;

            if (wr_prn)         prn <= bus.Wdata;
            else if (chip_edge) prn[13:0] <= prn_next;

            if (wr_cnt)      sample_count <= bus.Wdata;
            else if (push_q) sample_count <= sample_count + 32'd1;

            if (!en || tick) div_cnt <= '0;
            else             div_cnt <= div_cnt + 32'd1;

            s1_valid <= tick && en_next;
            if (tick) begin
                s1_mag <= lut_sv;
                s1_neg <= q[1] ^ prn_sign(prn) ^ ctrl[1];
            end

            push_q <= s1_valid && en_next;
            if (s1_valid && en_next) adc_q <= s2_out;

            epoch_q <= step_epoch;
            if (step_epoch)     epoch_seen <= 1'b1;
            else if (rd_status) epoch_seen <= 1'b0;
        end
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (bus.read) begin
            case (a)
                A_CTRL:       rdata = {30'd0, ctrl};
                A_CAR_FREQ:   rdata = car_freq;
                A_CAR_PHASE:  rdata = car_phase;
                A_CHIP_FREQ:  rdata = chip_freq;
                A_CHIP_PHASE: rdata = chip_phase;
                A_PRN:        rdata = prn;
                A_SAMPLE_DIV: rdata = sample_div;
                A_SAMPLE_CNT: rdata = sample_count;
                A_AMP:        rdata = {28'd0, amp};
                A_STATUS:     rdata = {30'd0, epoch_seen, ctrl[0]};
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.Rdata   = rdata;
    assign bus.ADC     = adc_q;
    assign bus.pushADC = push_q;
    assign bus.epoch   = epoch_q;
endmodule

// File: tb/tb_ssc_tx.sv
// tb_ssc_tx: directed + random runs of ssc_tx against a sample-level
// reference model (phase formula, PRN sequence, tick schedule).
module tb_ssc_tx;
    import ssc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ssc_tx_if bus ();

    ssc_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int last_edge, e0, d0;
    int exp_count = 0;
    bit exp_seen  = 1'b0;

    int          p_cyc[$];
    logic [15:0] p_val[$];
    int          e_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pushADC) begin
                p_cyc.push_back(cyc);
                p_val.push_back(bus.ADC);
            end
            if (bus.epoch) e_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr  = {16'h0, a};
        bus.Wdata = d;
        bus.write = 1'b1;
        last_edge = cyc + 1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic wr_at(input logic [15:0] a, input logic [31:0] d,
                         input int target);
        @(negedge clk);
        while (cyc + 1 < target) @(negedge clk);
        bus.addr  = {16'h0, a};
        bus.Wdata = d;
        bus.write = 1'b1;
        last_edge = cyc + 1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = {16'h0, a};
        bus.read = 1'b1;
        #1 d = bus.Rdata;
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    function automatic int sv_m(input int v);
        return (v * (16384 - v)) >>> 11;
    endfunction

    function automatic logic [15:0] smp_m(input logic [31:0] ph,
                                          input bit sgn, input bit inv,
                                          input int amp);
        int qd, ad, m, flips;
        qd = int'(ph[31:30]);
        ad = int'(ph[29:17]);
        if (qd == 1 || qd == 3) ad = 8191 - ad;
        m = sv_m(ad);
        flips = (qd >= 2 ? 1 : 0) + int'(sgn) + int'(inv);
        if (flips % 2 == 1) m = -m;
        if (m > 32767) m = 32767;
        m = m >>> amp;
        return m[15:0];
    endfunction

    function automatic int prn_m(input int s, input int hob, input int poly);
        int x, n;
        x = (s >> hob) & 1;
        n = ((s & ~(1 << hob)) << 1) & 16'h3FFF;
        if (x == 1) n = n ^ poly;
        return n;
    endfunction

    task automatic run_case(input string nm,
                            input logic [31:0] cf, input logic [31:0] cp,
                            input logic [31:0] hf, input logic [31:0] hp,
                            input logic [31:0] pr, input int dv,
                            input int amp, input bit inv, input int run);
        logic [31:0] r, ph, ch, chn;
        int st, hob, poly, t;
        int          xc[$];
        logic [15:0] xv[$];
        int          xe[$];
        wr(A_CTRL, 32'd0);
        rd(A_STATUS, r);
        chk({nm, ":status0"}, r, {30'd0, exp_seen, 1'b0});
        exp_seen = 1'b0;
        wr(A_CAR_FREQ, cf);
        wr(A_CAR_PHASE, cp);
        wr(A_CHIP_FREQ, hf);
        wr(A_CHIP_PHASE, hp);
        wr(A_PRN, pr);
        wr(A_SAMPLE_DIV, 32'(dv));
        wr(A_AMP, 32'(amp));
        p_cyc.delete();
        p_val.delete();
        e_cyc.delete();
        wr(A_CTRL, {30'd0, inv, 1'b1});
        e0 = last_edge;
        repeat (run) @(negedge clk);
        wr(A_CTRL, {30'd0, inv, 1'b0});
        d0 = last_edge;
        repeat (4) @(negedge clk);

        st   = int'(pr[13:0]);
        hob  = int'(pr[31:28]);
        poly = int'(pr[27:14]);
        ph   = cp;
        ch   = hp;
        for (t = e0 + dv; t <= d0 - 1; t += dv + 1) begin
            if (t <= d0 - 3) begin
                xc.push_back(t + 2);
                xv.push_back(smp_m(ph, bit'((st >> hob) & 1), inv, amp));
            end
            chn = ch + hf;
            if (!ch[31] && chn[31]) begin
                st = prn_m(st, hob, poly);
                if (st == 1) begin
                    xe.push_back(t + 1);
                    exp_seen = 1'b1;
                end
            end
            ph = ph + cf;
            ch = chn;
        end

        chk({nm, ":npush"}, 32'(p_cyc.size()), 32'(xc.size()));
        for (int i = 0; i < xc.size() && i < p_cyc.size(); i++) begin
            chk($sformatf("%s:cyc%0d", nm, i), 32'(p_cyc[i]), 32'(xc[i]));
            chk($sformatf("%s:adc%0d", nm, i), 32'(p_val[i]), 32'(xv[i]));
        end
        chk({nm, ":nepoch"}, 32'(e_cyc.size()), 32'(xe.size()));
        for (int i = 0; i < xe.size() && i < e_cyc.size(); i++)
            chk($sformatf("%s:ep%0d", nm, i), 32'(e_cyc[i]), 32'(xe[i]));
        if (xv.size() > 0)
            chk({nm, ":hold"}, 32'(bus.ADC), 32'(xv[xv.size() - 1]));
        exp_count += xc.size();
        rd(A_CAR_PHASE, r);
        chk({nm, ":carph"}, r, ph);
        rd(A_CHIP_PHASE, r);
        chk({nm, ":chipph"}, r, ch);
        rd(A_PRN, r);
        chk({nm, ":prn"}, r, {pr[31:14], st[13:0]});
        rd(A_SAMPLE_CNT, r);
        chk({nm, ":count"}, r, 32'(exp_count));
        rd(A_STATUS, r);
        chk({nm, ":status"}, r, {30'd0, exp_seen, 1'b0});
        exp_seen = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bus.addr  = '0;
        bus.Wdata = '0;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst:adc", 32'(bus.ADC), 32'd0);
        chk("rst:push", 32'(bus.pushADC), 32'd0);
        chk("rst:epoch", 32'(bus.epoch), 32'd0);
        rst = 1'b0;
        for (int ad = 16'h0800; ad <= 16'h0824; ad += 4) begin
            rd(16'(ad), r);
            chk($sformatf("rst:reg%h", ad[15:0]), r, 32'd0);
        end
        wr(16'h0828, 32'hFFFF_FFFF);
        rd(16'h0828, r);
        chk("unmapped", r, 32'd0);
        wr(A_CAR_FREQ, 32'd5);
        @(negedge clk);
        bus.addr = {16'h0, A_CAR_FREQ};
        #1 chk("rdata_noread", bus.Rdata, 32'd0);

        run_case("car", 32'h4000_0000, 0, 0, 0, 0, 0, 0, 1'b0, 4);
        chk("car:s0", 32'(p_val[0]), 32'h0);
        chk("car:s1", 32'(p_val[1]), 32'h7FFF);
        chk("car:s2", 32'(p_val[2]), 32'h0);
        chk("car:s3", 32'(p_val[3]), 32'h8001);
        chk("car:first", 32'(p_cyc[0]), 32'(e0 + 2));

        run_case("inv", 32'h4000_0000, 0, 0, 0, 0, 0, 0, 1'b1, 4);
        chk("inv:s1", 32'(p_val[1]), 32'h8001);
        chk("inv:s3", 32'(p_val[3]), 32'h7FFF);

        run_case("amp", 32'h4000_0000, 0, 0, 0, 0, 0, 4, 1'b0, 4);
        chk("amp:s1", 32'(p_val[1]), 32'h07FF);

        run_case("prn", 32'h1357_9BDF, 32'h0, 32'h8000_0000, 32'h0,
                 32'h3000_C001, 0, 0, 1'b0, 70);
        chk("prn:nep", 32'(e_cyc.size()), 32'd2);
        chk("prn:period", 32'(e_cyc[1] - e_cyc[0]), 32'd30);

        wr(A_CTRL, 32'd0);
        wr(A_CHIP_PHASE, 32'd0);
        wr(A_CHIP_FREQ, 32'h8000_0000);
        wr(A_PRN, 32'h3000_C009);
        wr(A_SAMPLE_DIV, 32'd0);
        wr(A_CTRL, 32'd1);
        repeat (3) @(negedge clk);
        rd(A_STATUS, r);
        chk("stat:set", r, 32'h3);
        rd(A_STATUS, r);
        chk("stat:clr", r, 32'h1);
        wr(A_CTRL, 32'd0);
        wr(A_SAMPLE_CNT, 32'd0);
        exp_count = 0;
        exp_seen  = 1'b0;

        run_case("div", 32'h0123_4567, 32'h89AB_CDEF, 32'h1000_0000,
                 32'h0, 32'h2000_4005, 9, 1, 1'b0, 29);
        chk("div:n", 32'(p_cyc.size()), 32'd2);
        chk("div:gap", 32'(p_cyc[1] - p_cyc[0]), 32'd10);

        wr(A_CTRL, 32'd0);
        wr(A_CHIP_FREQ, 32'd0);
        wr(A_CAR_FREQ, 32'h0100_0000);
        wr(A_CAR_PHASE, 32'd0);
        wr(A_SAMPLE_DIV, 32'd3);
        wr(A_CTRL, 32'd1);
        e0 = last_edge;
        wr_at(A_CAR_PHASE, 32'h1234_5678, e0 + 4);
        wr_at(A_CTRL, 32'd0, e0 + 6);
        rd(A_CAR_PHASE, r);
        chk("coll:carph", r, 32'h1234_5678);
        wr(A_SAMPLE_CNT, 32'd0);
        exp_count = 0;

        wr(A_CAR_FREQ, 32'h4000_0000);
        wr(A_CAR_PHASE, 32'h2000_0000);
        wr(A_SAMPLE_DIV, 32'd0);
        wr(A_AMP, 32'd0);
        wr(A_CTRL, 32'd1);
        repeat (4) @(negedge clk);
        chk("rst2:pre", 32'(bus.pushADC), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst2:adc", 32'(bus.ADC), 32'd0);
        chk("rst2:push", 32'(bus.pushADC), 32'd0);
        chk("rst2:epoch", 32'(bus.epoch), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        exp_seen  = 1'b0;
        rd(A_CTRL, r);
        chk("rst2:ctrl", r, 32'd0);
        run_case("rerst", 32'h4000_0000, 0, 0, 0, 0, 0, 0, 1'b0, 6);
        chk("rerst:first", 32'(p_cyc.size() > 0 ? p_cyc[0] : -1),
            32'(e0 + 2));

        for (int k = 0; k < 6; k++) begin
            logic [31:0] pr;
            pr = {4'($urandom_range(0, 13)), 14'($urandom),
                  14'($urandom)};
            run_case($sformatf("rnd%0d", k), $urandom, $urandom,
                     $urandom, $urandom, pr, $urandom_range(0, 3),
                     $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                     $urandom_range(10, 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
